// File: rtl/fine_delay_ctrl.sv
// Purpose: split a requested total fine delay across three cascaded tap stages and verify the read-back.
// Latency: done/error pulses SETTLE_CYCLES+1 cycles after accept, plus SETTLE_CYCLES+1 per retry.
// Backpressure: req_ready is low while a request is in flight; requests are never queued.
module fine_delay_ctrl #(
    parameter int TAP_W         = 5,
    parameter int REQ_W         = 7,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 3
) (
    input  logic             clk_400,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [REQ_W-1:0] req_delay,
    output logic             req_ready,
    output logic [TAP_W-1:0] fineDelay1,
    output logic [TAP_W-1:0] fineDelay2,
    output logic [TAP_W-1:0] fineDelay3,
    input  logic [TAP_W-1:0] fineDelay_data1,
    input  logic [TAP_W-1:0] fineDelay_data2,
    input  logic [TAP_W-1:0] fineDelay_data3,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             clamped,
    output logic [2:0]       mismatch,
    output logic [REQ_W-1:0] cur_delay
);

    localparam int SET_W   = 4;
    localparam int RETRY_W = 3;
    localparam int MAX_TAP = (2 ** TAP_W) - 1;

    localparam logic [REQ_W-1:0]   MAX_TAP_C   = REQ_W'(MAX_TAP);
    localparam logic [REQ_W-1:0]   MAX_TOTAL_C = REQ_W'(3 * MAX_TAP);
    localparam logic [SET_W-1:0]   SETTLE_LD_C = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

    typedef struct packed {
        logic [TAP_W-1:0] s3;
        logic [TAP_W-1:0] s2;
        logic [TAP_W-1:0] s1;
    } taps_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    state_t             state_q;
    taps_t              taps_q;
    taps_t              split_taps;
    logic [REQ_W-1:0]   cur_q;
    logic               clamped_q;
    logic [2:0]         mm_q;
    logic [2:0]         mm_now;
    logic [RETRY_W-1:0] retry_q;
    logic [SET_W-1:0]   settle_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic               ready_q;
    logic               req_over;
    logic [REQ_W-1:0]   tot;
    logic [REQ_W-1:0]   rem1;
    logic [REQ_W-1:0]   st1;
    logic [REQ_W-1:0]   st2;
    logic [REQ_W-1:0]   st3;

    // Fill stage 1 first, then stage 2; stage 3 takes whatever remains.
    always_comb begin
        req_over = (req_delay > MAX_TOTAL_C);
        tot      = req_over ? MAX_TOTAL_C : req_delay;
        st1      = (tot > MAX_TAP_C) ? MAX_TAP_C : tot;
        rem1     = tot - st1;
        st2      = (rem1 > MAX_TAP_C) ? MAX_TAP_C : rem1;
        st3      = rem1 - st2;
        split_taps.s1 = st1[TAP_W-1:0];
        split_taps.s2 = st2[TAP_W-1:0];
        split_taps.s3 = st3[TAP_W-1:0];
    end

    always_comb begin
        mm_now[0] = (fineDelay_data1 != taps_q.s1);
        mm_now[1] = (fineDelay_data2 != taps_q.s2);
        mm_now[2] = (fineDelay_data3 != taps_q.s3);
    end

    always_ff @(posedge clk_400 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            taps_q    <= '0;
            cur_q     <= '0;
            clamped_q <= 1'b0;
            mm_q      <= '0;
            retry_q   <= '0;
            settle_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        taps_q    <= split_taps;
                        cur_q     <= tot;
                        clamped_q <= req_over;
                        mm_q      <= '0;
                        retry_q   <= '0;
                        settle_q  <= SETTLE_LD_C;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= SETTLE;
                    end else begin
                        ready_q   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_q  <= CHECK;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                CHECK: begin
                    mm_q <= mm_now;
                    if (mm_now == 3'b000) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (retry_q != MAX_RETRY_C) begin
                        retry_q  <= retry_q + 1'b1;
                        settle_q <= SETTLE_LD_C;
                        state_q  <= SETTLE;
                    end else begin
                        // Taps stay at the commanded values so the host can inspect the failure.
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign fineDelay1 = taps_q.s1;
    assign fineDelay2 = taps_q.s2;
    assign fineDelay3 = taps_q.s3;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign clamped    = clamped_q;
    assign mismatch   = mm_q;
    assign cur_delay  = cur_q;

endmodule

// File: tb/tb_fine_delay_ctrl.sv
// Directed bench for fine_delay_ctrl: stimulus pushes hand-computed expectations, a monitor checks each done/error pulse.
module tb_fine_delay_ctrl;

    logic       clk_400;
    logic       reset_n;
    logic       req_valid;
    logic [6:0] req_delay;
    logic       req_ready;
    logic [4:0] fineDelay1, fineDelay2, fineDelay3;
    logic [4:0] fineDelay_data1, fineDelay_data2, fineDelay_data3;
    logic       busy, done, error, clamped;
    logic [2:0] mismatch;
    logic [6:0] cur_delay;

    logic       force2;
    int         cyc;
    int         tests;
    int         fails;

    typedef struct {
        int kind;     // 0 = done, 1 = error
        int accept;
        int lat;
        int f1, f2, f3;
        int cur;
        int cl;
        int mm;
    } exp_t;

    exp_t sb[$];

    fine_delay_ctrl dut (
        .clk_400         (clk_400),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_delay       (req_delay),
        .req_ready       (req_ready),
        .fineDelay1      (fineDelay1),
        .fineDelay2      (fineDelay2),
        .fineDelay3      (fineDelay3),
        .fineDelay_data1 (fineDelay_data1),
        .fineDelay_data2 (fineDelay_data2),
        .fineDelay_data3 (fineDelay_data3),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .clamped         (clamped),
        .mismatch        (mismatch),
        .cur_delay       (cur_delay)
    );

    assign fineDelay_data1 = fineDelay1;
    assign fineDelay_data2 = force2 ? 5'd0 : fineDelay2;
    assign fineDelay_data3 = fineDelay3;

    initial clk_400 = 1'b0;
    always #5 clk_400 = ~clk_400;

    initial cyc = 0;
    always @(posedge clk_400) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        tests = tests + 1;
        if (act != exp_v) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(negedge clk_400) begin
        if (reset_n && (done || error)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_and_error", int'(done && error), 0);
                chk("pulse_kind", error ? 1 : 0, e.kind);
                chk("pulse_latency", cyc - e.accept, e.lat);
                chk("tap1", int'(fineDelay1), e.f1);
                chk("tap2", int'(fineDelay2), e.f2);
                chk("tap3", int'(fineDelay3), e.f3);
                chk("cur_delay", int'(cur_delay), e.cur);
                chk("clamped", int'(clamped), e.cl);
                chk("mismatch", int'(mismatch), e.mm);
                chk("busy_at_pulse", int'(busy), 0);
            end
        end
    end

    // Caller is at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int dly, input int kind, input int lat,
                        input int f1, input int f2, input int f3,
                        input int cur, input int cl, input int mm,
                        output int waited);
        exp_t e;
        req_delay = 7'(dly);
        req_valid = 1'b1;
        waited    = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk_400);
            waited = waited + 1;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
        end else begin
            e.kind = kind; e.accept = cyc + 1; e.lat = lat;
            e.f1 = f1; e.f2 = f2; e.f3 = f3;
            e.cur = cur; e.cl = cl; e.mm = mm;
            sb.push_back(e);
            @(negedge clk_400);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk_400);
            n = n + 1;
        end
        if (sb.size() != 0 || busy) chk("idle_timeout", 0, 1);
        @(negedge clk_400);
    endtask

    initial begin
        int w;
        exp_t dropped;
        tests     = 0;
        fails     = 0;
        force2    = 1'b0;
        req_valid = 1'b0;
        req_delay = '0;
        reset_n   = 1'b0;
        #23;
        chk("rst_taps", int'({fineDelay3, fineDelay2, fineDelay1}), 0);
        chk("rst_cur_delay", int'(cur_delay), 0);
        chk("rst_flags", int'({busy, done, error, clamped}), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        @(negedge clk_400);
        reset_n = 1'b1;
        @(negedge clk_400);

        // 1: zero request
        send(0, 0, 5, 0, 0, 0, 0, 0, 0, w);
        chk("busy_after_accept", int'(busy), 1);
        wait_idle();

        // 2: nominal and full-range requests
        send(45, 0, 5, 31, 14, 0, 45, 0, 0, w);
        wait_idle();
        send(93, 0, 5, 31, 31, 31, 93, 0, 0, w);
        wait_idle();

        // 3: clamp, then clamp flag clears on next accept
        send(120, 0, 5, 31, 31, 31, 93, 1, 0, w);
        wait_idle();
        send(10, 0, 5, 10, 0, 0, 10, 0, 0, w);
        wait_idle();

        // 4: stage-2 stuck at 0 exhausts retries; then a transient fault recovers
        force2 = 1'b1;
        send(45, 1, 20, 31, 14, 0, 45, 0, 2, w);
        wait_idle();
        send(45, 0, 10, 31, 14, 0, 45, 0, 0, w);
        repeat (5) @(negedge clk_400);
        chk("mismatch_after_first_check", int'(mismatch), 2);
        chk("busy_during_retry", int'(busy), 1);
        force2 = 1'b0;
        wait_idle();

        // 5: request while busy is held off and taken in the done cycle
        send(45, 0, 5, 31, 14, 0, 45, 0, 0, w);
        chk("ready_low_while_busy", int'(req_ready), 0);
        send(60, 0, 5, 31, 29, 0, 60, 0, 0, w);
        chk("held_request_wait", w, 5);
        wait_idle();

        // 6: reset mid-settle aborts without a pulse
        send(45, 0, 5, 31, 14, 0, 45, 0, 0, w);
        @(negedge clk_400);
        #2;
        reset_n = 1'b0;
        dropped = sb.pop_back();
        #1;
        chk("abort_taps", int'({fineDelay3, fineDelay2, fineDelay1}), 0);
        chk("abort_flags", int'({req_ready, busy, done, error, clamped}), 0);
        chk("abort_mismatch_cur", int'({mismatch, cur_delay}), 0);
        @(negedge clk_400);
        @(negedge clk_400);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_400);
        chk("ready_after_reset", int'(req_ready), 1);
        send(31, 0, 5, 31, 0, 0, 31, 0, 0, w);
        wait_idle();
        repeat (10) @(negedge clk_400);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fine_delay_ctrl.md
Name: fine_delay_ctrl

Overview:
Control-side counterpart of the three-stage cascaded IDELAYE2 fine-delay chain. It accepts a requested total fine delay in taps and splits it across the three stage tap values (fineDelay1..3). It then waits for the delay pipeline to settle, checks the tap counter read-back (fineDelay_data1..3) against what was commanded, retries on mismatch, and reports done or error. It sits between the register or host-command interface and the fine-delay chain, in the clk_400 domain.

Parameters:
TAP_W, 5, width of each stage tap value; max per stage = 2^TAP_W-1 = 31.
REQ_W, 7, width of the requested total delay; max legal total = 3*31 = 93.
SETTLE_CYCLES, 4, cycles to wait after driving taps before comparing read-back; legal range 1..15.
MAX_RETRY, 3, re-checks allowed after the first failed compare; legal range 0..7.

Ports:
clk_400  in  1  400 MHz clock, same clock as the delay chain.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  a new total-delay request is present.
req_delay  in  REQ_W  requested total taps.
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
fineDelay1  out  TAP_W  stage-1 tap command.
fineDelay2  out  TAP_W  stage-2 tap command.
fineDelay3  out  TAP_W  stage-3 tap command.
fineDelay_data1  in  TAP_W  stage-1 read-back.
fineDelay_data2  in  TAP_W  stage-2 read-back.
fineDelay_data3  in  TAP_W  stage-3 read-back.
busy  out  1  high from accept until the done/error pulse.
done  out  1  one-cycle pulse: read-back matched.
error  out  1  one-cycle pulse: retries exhausted.
clamped  out  1  last accepted request exceeded 93; sticky until the next accept.
mismatch  out  3  per-stage mismatch flags (bit0 = stage 1) from the last compare; sticky until the next accept.
cur_delay  out  REQ_W  total taps currently commanded (after clamp).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - fineDelay1..3, cur_delay, mismatch, retry counter and settle counter = 0.
  - busy, done, error, clamped = 0; req_ready = 1 once in IDLE.
- Reset mid-operation aborts immediately. No done or error pulse is produced for the aborted request.
- Split, computed combinationally from req_delay and registered on the accept edge:
  - t = min(req_delay, 93); clamped = (req_delay > 93).
  - s1 = min(t, 31); s2 = min(t - s1, 31); s3 = t - s1 - s2.
  - Invariant: s1 + s2 + s3 = t.
- States:
  - IDLE: req_ready = 1. On accept: register s1..s3 into fineDelay1..3 and t into cur_delay; update clamped; clear mismatch and the retry counter; load the settle counter = SETTLE_CYCLES - 1; busy = 1; go to SETTLE.
  - SETTLE: decrement the counter each cycle; go to CHECK when it reads 0. Occupies exactly SETTLE_CYCLES cycles.
  - CHECK (1 cycle): compare each fineDelay_dataN to fineDelayN and register mismatch[N-1].
    - All equal: done = 1 next cycle, busy = 0, go to IDLE.
    - Mismatch and retry counter < MAX_RETRY: increment the counter, reload the settle counter, go to SETTLE. Taps are held unchanged.
    - Mismatch and retry counter = MAX_RETRY: error = 1 next cycle, busy = 0, go to IDLE. Taps are held at the commanded values and are not reverted.
- Latency:
  - Accept at edge E0; done/error pulse visible from edge E0 + SETTLE_CYCLES + 1 for one cycle.
  - Each retry adds SETTLE_CYCLES + 1 cycles.
  - Worst case to error = (MAX_RETRY + 1) * (SETTLE_CYCLES + 1).
- req_valid while busy is ignored: req_ready = 0, nothing is queued, and the requester must hold its request.
- A new request may be accepted in the same cycle the done/error pulse is high, since state is already IDLE.
- Read-back is sampled only in CHECK. Transients during SETTLE are irrelevant.
- done and error are never high together.

Test Plan (SETTLE_CYCLES = 4, MAX_RETRY = 3, read-back looped from the commands unless stated):
1. Reset released, req_delay = 0 accepted -> taps 0/0/0; done pulse 5 cycles after accept; mismatch = 000; clamped = 0.
2. req_delay = 45 -> taps 31/14/0, cur_delay = 45, done at +5. Then req_delay = 93 -> taps 31/31/31, done at +5.
3. req_delay = 120 -> clamped = 1, cur_delay = 93, taps 31/31/31, done; the next request of 10 -> clamped = 0, taps 10/0/0.
4. Stage-2 read-back forced to 0, req_delay = 45 -> error pulse 20 cycles after accept, mismatch = 010, no done pulse, taps held at 31/14/0. Releasing the force after the first compare -> done at +10 instead.
5. req_valid asserted with 60 while busy on request 45 -> ignored (req_ready = 0); held req_valid is accepted in the done cycle -> taps 31/29/0.
6. reset_n pulsed low mid-SETTLE -> all outputs 0 asynchronously, no done/error pulse; after release, req_ready = 1 and a new request of 31 -> taps 31/0/0, done.
